operand_fwd_stage: RTL and testbench

Parametrised operand-select and forwarding stage between decode and execute. Each cycle it resolves every source operand of the issuing instruction against an internal history of in-flight results. The history is youngest-first with a configurable depth. For each operand it selects forwarded data, the register-file value, or the PC. It registers the chosen operands into the execute boundary under a valid/ready handshake and stalls issue on load-use hazards until the load data is filled.

---
 rtl/operand_fwd_stage.sv | 175 +++++++++++++++++
 tb/tb_operand_fwd_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fwd_stage.sv
// Operand select / forwarding stage between decode and execute, with a youngest-first result history.
// Optional statistics counters are built when OPERAND_FWD_STATS_EN is defined.
module operand_fwd_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int FWD_DEPTH      = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  in_rs,
  input  logic [NUM_SRC-1:0]                 in_use_pc,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      in_rf_data,
  input  logic [DATA_WIDTH-1:0]              in_pc,
  input  logic                               prod_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          prod_rd,
  input  logic [DATA_WIDTH-1:0]              prod_data,
  input  logic                               prod_is_load,
  input  logic                               fill_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          fill_rd,
  input  logic [DATA_WIDTH-1:0]              fill_data,
  output logic                               stall,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_SRC*DATA_WIDTH-1:0]      out_op,
  output logic [NUM_SRC-1:0]                 out_fwd,
  output logic [31:0]                        stat_stall_cnt,
  output logic [31:0]                        stat_fwd_cnt
);

  logic [FWD_DEPTH-1:0]      r_hv;
  logic [FWD_DEPTH-1:0]      r_hp;
  logic [REG_ADDR_WIDTH-1:0] r_hrd   [FWD_DEPTH];
  logic [DATA_WIDTH-1:0]     r_hdata [FWD_DEPTH];

  logic [FWD_DEPTH-1:0]          w_fill_hit;
  logic [NUM_SRC*DATA_WIDTH-1:0] w_op;
  logic [NUM_SRC-1:0]            w_fwd;
  logic [NUM_SRC-1:0]            w_haz;
  logic [REG_ADDR_WIDTH-1:0]     w_rs;
  logic                          w_hit;
  logic                          w_hit_p;
  logic                          w_hit_f;
  logic [DATA_WIDTH-1:0]         w_hit_d;
  logic                          w_stall;
  logic                          w_xfer;

  logic                          r_out_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] r_out_op;
  logic [NUM_SRC-1:0]            r_out_fwd;

  // Fill targets the oldest matching pending entry: ascending scan, later hits overwrite.
  always_comb begin
    w_fill_hit = '0;
    for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
      if (fill_valid && r_hv[i] && r_hp[i] && (r_hrd[i] == fill_rd)) begin
        w_fill_hit    = '0;
        w_fill_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_op    = '0;
    w_fwd   = '0;
    w_haz   = '0;
    w_rs    = '0;
    w_hit   = 1'b0;
    w_hit_p = 1'b0;
    w_hit_f = 1'b0;
    w_hit_d = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_rs    = in_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      w_hit   = 1'b0;
      w_hit_p = 1'b0;
      w_hit_f = 1'b0;
      w_hit_d = '0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        if (!w_hit && r_hv[i] && (r_hrd[i] == w_rs)) begin
          w_hit   = 1'b1;
          w_hit_p = r_hp[i];
          w_hit_f = w_fill_hit[i];
          w_hit_d = r_hdata[i];
        end
      end
      if (in_use_pc[k]) begin
        w_op[k*DATA_WIDTH +: DATA_WIDTH] = in_pc;
      end else if (w_rs == '0) begin
        w_op[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (w_hit) begin
        if (!w_hit_p) begin
          w_op[k*DATA_WIDTH +: DATA_WIDTH] = w_hit_d;
          w_fwd[k] = 1'b1;
        end else if (w_hit_f) begin
          w_op[k*DATA_WIDTH +: DATA_WIDTH] = fill_data;
          w_fwd[k] = 1'b1;
        end else begin
          w_haz[k] = 1'b1;
        end
      end else begin
        w_op[k*DATA_WIDTH +: DATA_WIDTH] = in_rf_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_stall  = in_valid && (|w_haz);
  assign in_ready = !w_stall && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;
  assign stall    = w_stall;

  // History shifts every cycle; a same-cycle fill lands in the entry's new slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hv <= '0;
      r_hp <= '0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        r_hrd[i]   <= '0;
        r_hdata[i] <= '0;
      end
    end else begin
      r_hv[0]    <= prod_valid && (prod_rd != '0);
      r_hp[0]    <= prod_valid && (prod_rd != '0) && prod_is_load;
      r_hrd[0]   <= prod_rd;
      r_hdata[0] <= prod_data;
      for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
        r_hv[i]    <= r_hv[i-1];
        r_hp[i]    <= r_hp[i-1] && !w_fill_hit[i-1];
        r_hrd[i]   <= r_hrd[i-1];
        r_hdata[i] <= w_fill_hit[i-1] ? fill_data : r_hdata[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_fwd   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_op    <= w_op;
      r_out_fwd   <= w_fwd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_op    = r_out_op;
  assign out_fwd   = r_out_fwd;

`ifdef OPERAND_FWD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_xfer && (|w_fwd) && (r_fwd_cnt != '1)) r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign stat_stall_cnt = r_stall_cnt;
  assign stat_fwd_cnt   = r_fwd_cnt;
`else
  assign stat_stall_cnt = '0;
  assign stat_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Self-checking bench for operand_fwd_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_operand_fwd_stage;
  localparam int DW = 32;
  localparam int RA = 5;
  localparam int NS = 2;
  localparam int D  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready;
  logic [NS*RA-1:0]  in_rs;
  logic [NS-1:0]     in_use_pc;
  logic [NS*DW-1:0]  in_rf_data;
  logic [DW-1:0]     in_pc;
  logic              prod_valid, prod_is_load;
  logic [RA-1:0]     prod_rd;
  logic [DW-1:0]     prod_data;
  logic              fill_valid;
  logic [RA-1:0]     fill_rd;
  logic [DW-1:0]     fill_data;
  logic              stall, out_valid, out_ready;
  logic [NS*DW-1:0]  out_op;
  logic [NS-1:0]     out_fwd;
  logic [31:0]       stat_stall_cnt, stat_fwd_cnt;

  operand_fwd_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RA), .NUM_SRC(NS), .FWD_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
    .in_use_pc(in_use_pc), .in_rf_data(in_rf_data), .in_pc(in_pc), .prod_valid(prod_valid),
    .prod_rd(prod_rd), .prod_data(prod_data), .prod_is_load(prod_is_load), .fill_valid(fill_valid),
    .fill_rd(fill_rd), .fill_data(fill_data), .stall(stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_fwd(out_fwd),
    .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          v;
    logic          p;
    logic [RA-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t            hist[$];
  logic            m_ov;
  logic [NS*DW-1:0] m_op;
  logic [NS-1:0]   m_fwd;
  logic [31:0]     m_scnt, m_fcnt;
  int              m_viol;

  function automatic int fill_idx();
    int r = -1;
    if (fill_valid)
      for (int i = 0; i < hist.size(); i++)
        if (hist[i].v && hist[i].p && hist[i].rd == fill_rd) r = i;
    return r;
  endfunction

  function automatic void resolve(output logic st, output logic [NS*DW-1:0] ops, output logic [NS-1:0] fw);
    int fi = fill_idx();
    logic haz = 1'b0;
    ops = '0;
    fw  = '0;
    for (int k = 0; k < NS; k++) begin
      logic [RA-1:0] rs = in_rs[k*RA +: RA];
      int w = -1;
      for (int i = 0; i < hist.size(); i++)
        if (w < 0 && hist[i].v && hist[i].rd == rs) w = i;
      if (in_use_pc[k])            ops[k*DW +: DW] = in_pc;
      else if (rs == 0)            ops[k*DW +: DW] = '0;
      else if (w < 0)              ops[k*DW +: DW] = in_rf_data[k*DW +: DW];
      else if (!hist[w].p)         begin ops[k*DW +: DW] = hist[w].d; fw[k] = 1'b1; end
      else if (w == fi)            begin ops[k*DW +: DW] = fill_data; fw[k] = 1'b1; end
      else                         haz = 1'b1;
    end
    st = in_valid && haz;
  endfunction

  function automatic logic [31:0] exp_scnt();
`ifdef OPERAND_FWD_STATS_EN
    return m_scnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_fcnt();
`ifdef OPERAND_FWD_STATS_EN
    return m_fcnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back('0);
    m_ov = 1'b0; m_op = '0; m_fwd = '0; m_scnt = '0; m_fcnt = '0;
  endtask

  // Advances the model with the inputs the DUT samples at the coming edge.
  task automatic model_step();
    logic st, rdy;
    logic [NS*DW-1:0] ops;
    logic [NS-1:0] fw;
    int fi;
    ent_t e;
    if (rst) begin
      model_reset();
    end else begin
      resolve(st, ops, fw);
      rdy = !st && (!m_ov || out_ready);
      if (in_valid && rdy) begin
        m_ov = 1'b1; m_op = ops; m_fwd = fw;
        if (fw != 0 && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      end else if (out_ready) m_ov = 1'b0;
      if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      fi = fill_idx();
      if (fi >= 0) begin hist[fi].p = 1'b0; hist[fi].d = fill_data; end
      if (hist[D-1].v && hist[D-1].p) m_viol++;
      void'(hist.pop_back());
      e.v = prod_valid && prod_rd != 0; e.p = prod_is_load; e.rd = prod_rd; e.d = prod_data;
      hist.push_front(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_rs = '0; in_use_pc = '0; in_rf_data = '0; in_pc = '0;
    prod_valid = 0; prod_rd = '0; prod_data = '0; prod_is_load = 0;
    fill_valid = 0; fill_rd = '0; fill_data = '0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick();
    in_valid = 1; in_rs = {5'd3, 5'd2}; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_op !== '0 || out_fwd !== '0) begin n_fail++; $display("FAIL reset_out_op: got %h/%b expected 0/0", out_op, out_fwd); end
    n_checks++; if (stat_stall_cnt !== 0 || stat_fwd_cnt !== 0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_stall_cnt, stat_fwd_cnt); end
    tick(); rst = 0; idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    prod_valid = 1; prod_rd = 5'd5; prod_data = 32'hAAAA_0001; tick();
    idle(); in_valid = 1; in_rs = {5'd0, 5'd5}; #1;
    n_checks++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_nostall: got stall=%b rdy=%b expected 0/1", stall, in_ready); end
    tick(); idle(); #1;
    n_checks++; if (out_valid !== 1'b1 || out_op[DW-1:0] !== 32'hAAAA_0001 || out_fwd[0] !== 1'b1)
      begin n_fail++; $display("FAIL b2b_fwd: got v=%b op=%h fwd=%b expected 1/aaaa0001/1", out_valid, out_op[DW-1:0], out_fwd[0]); end
  endtask

  task automatic test_youngest();
    do_reset();
    prod_valid = 1; prod_rd = 5'd3; prod_data = 32'h11; tick();
    prod_data = 32'h22; tick();
    idle(); in_valid = 1; in_rs = {5'd0, 5'd3}; in_rf_data = {32'h0, 32'h99}; tick();
    idle(); #1;
    n_checks++; if (out_op[DW-1:0] !== 32'h22 || out_fwd[0] !== 1'b1)
      begin n_fail++; $display("FAIL youngest: got %h/%b expected 00000022/1", out_op[DW-1:0], out_fwd[0]); end
  endtask

  task automatic test_load_use();
    do_reset();
    prod_valid = 1; prod_rd = 5'd7; prod_is_load = 1; prod_data = 32'h1234; tick();
    idle(); in_valid = 1; in_rs = {5'd7, 5'd0}; #1;
    n_checks++; if (stall !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got stall=%b rdy=%b expected 1/0", stall, in_ready); end
    tick();
    fill_valid = 1; fill_rd = 5'd7; fill_data = 32'hDEAD_BEEF; #1;
    n_checks++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_bypass: got stall=%b rdy=%b expected 0/1", stall, in_ready); end
    tick(); idle(); #1;
    n_checks++; if (out_valid !== 1'b1 || out_op[2*DW-1:DW] !== 32'hDEAD_BEEF || out_fwd[1] !== 1'b1)
      begin n_fail++; $display("FAIL load_use_data: got v=%b op=%h fwd=%b expected 1/deadbeef/1", out_valid, out_op[2*DW-1:DW], out_fwd[1]); end
  endtask

  task automatic test_depth_aging();
    do_reset();
    prod_valid = 1; prod_rd = 5'd9; prod_data = 32'h55; tick();
    idle(); for (int i = 0; i < D; i++) tick();
    in_valid = 1; in_rs = {5'd0, 5'd9}; in_rf_data = {32'h0, 32'h66}; tick();
    idle(); #1;
    n_checks++; if (out_op[DW-1:0] !== 32'h66 || out_fwd[0] !== 1'b0)
      begin n_fail++; $display("FAIL depth_aging: got %h/%b expected 00000066/0", out_op[DW-1:0], out_fwd[0]); end
  endtask

  task automatic test_pc_zero_backpressure();
    do_reset();
    out_ready = 0; in_valid = 1; in_use_pc = 2'b01; in_pc = 32'h8000_0010;
    in_rs = {5'd0, 5'd4}; in_rf_data = {32'h1234_5678, 32'h0BAD_0BAD}; tick();
    in_pc = 32'h9000_0000; in_rs = {5'd2, 5'd1};
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold_ctl: got v=%b rdy=%b expected 1/0", out_valid, in_ready); end
      n_checks++; if (out_op !== {32'h0, 32'h8000_0010})
        begin n_fail++; $display("FAIL bp_hold_op: got %h expected 0000000080000010", out_op); end
      tick();
    end
    idle(); tick(); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_stats();
    logic [31:0] e_s, e_f;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      prod_valid = 1; prod_rd = 5'd4; prod_is_load = 1; tick();
      idle(); in_valid = 1; in_rs = {5'd0, 5'd4}; tick(); tick();
      fill_valid = 1; fill_rd = 5'd4; fill_data = 32'h44 + r; tick();
      idle();
    end
    prod_valid = 1; prod_rd = 5'd6; prod_data = 32'h66; tick();
    idle(); in_valid = 1; in_rs = {5'd0, 5'd6}; tick();
    idle(); #1;
`ifdef OPERAND_FWD_STATS_EN
    e_s = 32'd4; e_f = 32'd3;
`else
    e_s = 32'd0; e_f = 32'd0;
`endif
    n_checks++; if (stat_stall_cnt !== e_s) begin n_fail++; $display("FAIL stats_stall: got %0d expected %0d", stat_stall_cnt, e_s); end
    n_checks++; if (stat_fwd_cnt !== e_f) begin n_fail++; $display("FAIL stats_fwd: got %0d expected %0d", stat_fwd_cnt, e_f); end
    do_reset(); #1;
    n_checks++; if (stat_stall_cnt !== 0 || stat_fwd_cnt !== 0)
      begin n_fail++; $display("FAIL stats_clear: got %0d/%0d expected 0/0", stat_stall_cnt, stat_fwd_cnt); end
  endtask

  task automatic test_random();
    logic e_st, e_rdy;
    logic [NS*DW-1:0] e_op;
    logic [NS-1:0] e_fw;
    int pend[$];
    do_reset();
    m_viol = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NS; k++) in_rs[k*RA +: RA] = RA'($urandom_range(0, 7));
      in_use_pc  = NS'($urandom_range(0, 7) == 0 ? $urandom : 0);
      in_rf_data = {$urandom, $urandom};
      in_pc      = $urandom;
      prod_valid = $urandom_range(0, 1) == 1;
      prod_rd    = RA'($urandom_range(0, 7));
      prod_data  = $urandom;
      prod_is_load = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      fill_data  = $urandom;
      pend.delete();
      for (int i = 0; i < D; i++) if (hist[i].v && hist[i].p) pend.push_back(i);
      fill_valid = 1'b0; fill_rd = '0;
      if (hist[D-1].v && hist[D-1].p) begin
        fill_valid = 1'b1; fill_rd = hist[D-1].rd;
      end else if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        fill_valid = 1'b1; fill_rd = hist[pend[$urandom_range(0, pend.size()-1)]].rd;
      end else if ($urandom_range(0, 9) == 0) begin
        fill_valid = 1'b1; fill_rd = RA'($urandom_range(0, 31));
      end
      #1;
      resolve(e_st, e_op, e_fw);
      e_rdy = !e_st && (!m_ov || out_ready);
      n_checks++; if (stall !== e_st) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, e_st); end
      n_checks++; if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, in_ready, e_rdy); end
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, out_valid, m_ov); end
      n_checks++; if (out_op !== m_op || out_fwd !== m_fwd)
        begin n_fail++; $display("FAIL rnd_out_op c=%0d: got %h/%b expected %h/%b", c, out_op, out_fwd, m_op, m_fwd); end
      n_checks++; if (stat_stall_cnt !== exp_scnt() || stat_fwd_cnt !== exp_fcnt())
        begin n_fail++; $display("FAIL rnd_stats c=%0d: got %0d/%0d expected %0d/%0d", c, stat_stall_cnt, stat_fwd_cnt, exp_scnt(), exp_fcnt()); end
      tick();
    end
    rst = 0; idle();
    n_checks++; if (m_viol !== 0) begin n_fail++; $display("FAIL rnd_pending_aged_out: got %0d expected 0", m_viol); end
  endtask

  initial begin
    idle(); rst = 1; m_viol = 0; model_reset();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_youngest();
    test_load_use();
    test_depth_aging();
    test_pc_zero_backpressure();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
